// File: rtl/jvm_xlat_pkg.sv
// Shared types and constants for the JVM-to-ARM translation sequencer.
package jvm_xlat_pkg;

    typedef enum logic [1:0] {S_OP, S_CNT, S_PARAM, S_EMIT} state_t;

    localparam logic [7:0]  OPC_WIDE = 8'hC4;
    localparam int unsigned TPL_END  = 0;

    // Operand byte count after the wide doubling, clamped to the operand register size.
    function automatic int unsigned eff_count(input logic [2:0] cnt, input logic dbl,
                                              input int unsigned max_b);
        int unsigned n;
        n = 32'(cnt);
        if (dbl) n = n << 1;
        if (n > max_b) n = max_b;
        return n;
    endfunction

endpackage

// File: rtl/jvm_xlat_seq_if.sv
// Bytecode-in / ARM-word-out stream pair of the translation sequencer.
interface jvm_xlat_seq_if #(parameter int WORD_W = 32);

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_last;

    modport master (output in_valid, in_byte, out_ready,
                    input  in_ready, out_valid, out_word, out_last);
    modport slave  (input  in_valid, in_byte, out_ready,
                    output in_ready, out_valid, out_word, out_last);

endinterface

// File: rtl/jvm_operand_acc.sv
// Big-endian operand shift register with a remaining-byte down-counter.
module jvm_operand_acc #(
    parameter  int MAX_BYTES = 4,
    parameter  int IMM_W     = 12,
    localparam int OP_W      = 8 * MAX_BYTES,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic [7:0]       data,
    output logic             last,
    output logic [IMM_W-1:0] imm
);

    logic [OP_W-1:0]  operand;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand   <= '0;
            remaining <= '0;
        end else begin
            if (clr)
                operand <= '0;
            else if (shift)
                operand <= (operand << 8) | OP_W'(data);
            if (load)
                remaining <= load_cnt;
            else if (shift && remaining != '0)
                remaining <= remaining - CNT_W'(1);
        end
    end

    // High when the byte being shifted in is the final operand byte.
    assign last = (remaining == CNT_W'(1));
    assign imm  = operand[IMM_W-1:0];

endmodule

// File: rtl/jvm_xlat_seq.sv
// Bytecode-to-ARM sequencer: wide prefix, operand gathering, linked template walk.
module jvm_xlat_seq
    import jvm_xlat_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int WORD_W    = 32,
    parameter int MAX_BYTES = 4,
    parameter int IMM_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    jvm_xlat_seq_if.slave     bus,
    output logic [7:0]        rom_opcode,
    input  logic [2:0]        cnt_bytes,
    input  logic              cnt_wide_ok,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] tpl_addr,
    input  logic [WORD_W-1:0] tpl_word,
    input  logic [ADDR_W-1:0] tpl_next,
    input  logic              tpl_patch,
    output logic              busy,
    output logic              err_wide
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    state_t           state;
    logic             wide;
    logic             acc_last;
    logic [IMM_W-1:0] imm;
    logic [CNT_W-1:0] cnt_sat;
    logic             in_fire, is_wide, tpl_end, next_end, emit;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign is_wide  = (bus.in_byte == OPC_WIDE);
    assign tpl_end  = (tpl_addr == ADDR_W'(TPL_END));
    assign next_end = (tpl_next == ADDR_W'(TPL_END));
    assign cnt_sat  = CNT_W'(eff_count(cnt_bytes, wide & cnt_wide_ok, int'(MAX_BYTES)));
    assign emit     = (state == S_EMIT) && !tpl_end;

    assign bus.in_ready  = rst_n && (state == S_OP || state == S_PARAM);
    assign bus.out_valid = emit;
    assign bus.out_last  = emit & next_end;
    assign bus.out_word  = emit ? (tpl_word | (tpl_patch ? WORD_W'(imm) : '0)) : '0;
    assign busy          = (state != S_OP);

    jvm_operand_acc #(.MAX_BYTES(MAX_BYTES), .IMM_W(IMM_W)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      ((state == S_OP) && in_fire && !is_wide),
        .load     (state == S_CNT),
        .shift    ((state == S_PARAM) && in_fire),
        .load_cnt (cnt_sat),
        .data     (bus.in_byte),
        .last     (acc_last),
        .imm      (imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OP;
            wide       <= 1'b0;
            err_wide   <= 1'b0;
            rom_opcode <= '0;
            tpl_addr   <= '0;
        end else begin
            err_wide <= 1'b0;
            case (state)
                S_OP: if (in_fire) begin
                    if (is_wide) begin
                        err_wide <= wide;
                        wide     <= 1'b1;
                    end else begin
                        rom_opcode <= bus.in_byte;
                        state      <= S_CNT;
                    end
                end
                S_CNT: begin
                    err_wide <= wide & ~cnt_wide_ok;
                    tpl_addr <= start_addr;
                    state    <= (cnt_sat == '0) ? S_EMIT : S_PARAM;
                end
                S_PARAM: if (in_fire && acc_last) state <= S_EMIT;
                S_EMIT: begin
                    // An empty template still ends the instruction and drops the prefix.
                    if (tpl_end) begin
                        state <= S_OP;
                        wide  <= 1'b0;
                    end else if (bus.out_ready) begin
                        tpl_addr <= tpl_next;
                        if (next_end) begin
                            state <= S_OP;
                            wide  <= 1'b0;
                        end
                    end
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_jvm_xlat_seq.sv
// Scoreboard bench: ROM contents live in arrays, expected words come from walking them.
module tb_jvm_xlat_seq;

    localparam int ADDR_W = 8, WORD_W = 32, MAX_BYTES = 4, IMM_W = 12;

    typedef struct packed {logic [31:0] w; logic last;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    jvm_xlat_seq_if #(.WORD_W(WORD_W)) bus();

    logic [7:0]        rom_opcode;
    logic [2:0]        cnt_bytes;
    logic              cnt_wide_ok;
    logic [ADDR_W-1:0] start_addr, tpl_addr, tpl_next;
    logic [WORD_W-1:0] tpl_word;
    logic              tpl_patch, busy, err_wide;

    logic [2:0]  cnt_rom   [256];
    logic        ok_rom    [256];
    logic [7:0]  start_rom [256];
    logic [31:0] word_rom  [256];
    logic [7:0]  next_rom  [256];
    logic        patch_rom [256];

    assign cnt_bytes   = cnt_rom[rom_opcode];
    assign cnt_wide_ok = ok_rom[rom_opcode];
    assign start_addr  = start_rom[rom_opcode];
    assign tpl_word    = word_rom[tpl_addr];
    assign tpl_next    = next_rom[tpl_addr];
    assign tpl_patch   = patch_rom[tpl_addr];

    jvm_xlat_seq #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .MAX_BYTES(MAX_BYTES), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rom_opcode(rom_opcode),
        .cnt_bytes(cnt_bytes), .cnt_wide_ok(cnt_wide_ok), .start_addr(start_addr),
        .tpl_addr(tpl_addr), .tpl_word(tpl_word), .tpl_next(tpl_next), .tpl_patch(tpl_patch),
        .busy(busy), .err_wide(err_wide)
    );

    always #5 clk = ~clk;

    int   vectors = 0, miscompares = 0;
    int   cyc = 0;
    int   exp_err = 0, seen_err = 0, hs_count = 0;
    int   rdy_mode = 0;
    exp_t exp_q[$];
    logic [7:0] fixed_ops[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = one ready cycle in five.
    initial begin : rdy_drv
        int ph;
        ph = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 9) < 7);
                default: begin bus.out_ready = (ph == 4); ph = (ph + 1) % 5; end
            endcase
        end
    end

    initial begin : monitor
        logic [31:0] held;
        bit          stalled;
        exp_t        e;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (err_wide) seen_err++;
            if (stalled) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_word", 64'(bus.out_word), 64'(held));
            end
            stalled = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_word: actual %0h, expected no word", bus.out_word);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", 64'(bus.out_word), 64'(e.w));
                        check("out_last", 64'(bus.out_last), 64'(e.last));
                        hs_count++;
                    end
                end else begin
                    stalled = 1;
                    held = bus.out_word;
                end
            end else begin
                check("idle_outputs", {31'd0, bus.out_last, bus.out_word}, 64'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready 0, expected 1");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Reference model: operand count rules, big-endian assembly, template chain walk.
    task automatic issue(input int npre, input logic [7:0] op, input bit gaps, input bit chk_lat);
        int          n, a, guard, c0, lat;
        logic [31:0] opv;
        logic [7:0]  b;
        logic [7:0]  ops[$];
        exp_t        e;
        n = int'(cnt_rom[op]);
        if (npre > 0 && ok_rom[op]) n = 2 * n;
        if (npre > 1) exp_err += npre - 1;
        if (npre > 0 && !ok_rom[op]) exp_err++;
        if (n > MAX_BYTES) n = MAX_BYTES;
        opv = 0;
        for (int i = 0; i < n; i++) begin
            b = (fixed_ops.size() > 0) ? fixed_ops.pop_front() : 8'($urandom);
            ops.push_back(b);
            opv = (opv << 8) | 32'(b);
        end
        a = int'(start_rom[op]);
        guard = 0;
        while (a != 0 && guard < 256) begin
            e.w    = word_rom[a] | (patch_rom[a] ? (opv % 4096) : 32'd0);
            e.last = (next_rom[a] == 8'd0);
            exp_q.push_back(e);
            a = int'(next_rom[a]);
            guard++;
        end
        repeat (npre) send_byte(8'hC4);
        send_byte(op);
        c0 = cyc;
        foreach (ops[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(ops[i]);
        end
        if (chk_lat && start_rom[op] != 8'd0) begin
            lat = 0;
            @(negedge clk);
            while (!bus.out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            check("first_valid_cycle", 64'(cyc - c0), 64'(1 + n));
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_timeout"}, 64'(t >= 3000), 64'd0);
        repeat (2) @(negedge clk);
        check({name, "_err_wide"}, 64'(seen_err), 64'(exp_err));
    endtask

    task automatic setup_directed();
        cnt_rom[8'h03] = 3'd0; ok_rom[8'h03] = 1'b0; start_rom[8'h03] = 8'd5;
        word_rom[5] = 32'hE3A00000; next_rom[5] = 8'd0; patch_rom[5] = 1'b0;
        cnt_rom[8'h10] = 3'd1; ok_rom[8'h10] = 1'b0; start_rom[8'h10] = 8'd6;
        word_rom[6] = 32'hE3A00000; next_rom[6] = 8'd0; patch_rom[6] = 1'b1;
        cnt_rom[8'h15] = 3'd1; ok_rom[8'h15] = 1'b1; start_rom[8'h15] = 8'd8;
        word_rom[8] = 32'hE5900000; next_rom[8] = 8'd0; patch_rom[8] = 1'b1;
        cnt_rom[8'h20] = 3'd0; ok_rom[8'h20] = 1'b0; start_rom[8'h20] = 8'd7;
        word_rom[7] = 32'hE1A00001; next_rom[7] = 8'd9; patch_rom[7] = 1'b0;
        word_rom[9] = 32'hE2800000; next_rom[9] = 8'd2; patch_rom[9] = 1'b1;
        word_rom[2] = 32'hE12FFF1E; next_rom[2] = 8'd0; patch_rom[2] = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hs0, t, npre;
        logic [7:0] op;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        for (int a = 0; a < 256; a++) begin
            cnt_rom[a] = '0; ok_rom[a] = 1'b0; start_rom[a] = '0;
            word_rom[a] = '0; next_rom[a] = '0; patch_rom[a] = 1'b0;
        end
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_word", 64'(bus.out_word), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_wide", 64'(err_wide), 64'd0);
        check("rst_rom_opcode", 64'(rom_opcode), 64'd0);
        check("rst_tpl_addr", 64'(tpl_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);

        setup_directed();
        rdy_mode = 0;
        issue(0, 8'h03, 0, 1);
        wait_idle("iconst_0");
        fixed_ops = '{8'h7F};
        issue(0, 8'h10, 0, 1);
        wait_idle("bipush");
        fixed_ops = '{8'h01, 8'h2C};
        issue(1, 8'h15, 0, 1);
        wait_idle("wide_iload");
        fixed_ops = '{8'h05};
        issue(1, 8'h10, 0, 1);
        wait_idle("wide_nonwide");
        fixed_ops = '{8'hAB, 8'hCD};
        issue(2, 8'h15, 0, 1);
        wait_idle("double_wide");
        rdy_mode = 2;
        issue(0, 8'h20, 0, 1);
        wait_idle("backpressure");

        // Random ROMs: chains always point forward, so every walk terminates.
        for (int a = 1; a < 256; a++) begin
            word_rom[a]  = $urandom;
            patch_rom[a] = 1'($urandom_range(0, 1));
            next_rom[a]  = (a < 250 && $urandom_range(0, 2) != 0) ? 8'(a + $urandom_range(1, 5)) : 8'd0;
        end
        for (int o = 0; o < 256; o++) begin
            cnt_rom[o]   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 3));
            ok_rom[o]    = 1'($urandom_range(0, 1));
            start_rom[o] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        end
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            op = 8'($urandom_range(0, 255));
            if (op == 8'hC4) op = 8'h00;
            npre = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 15) == 0) npre = 2;
            if (start_rom[op] == 8'd0) npre = 0;
            issue(npre, op, 1, 0);
            wait_idle("random");
        end

        // Abort in the middle of a three-word template chain.
        setup_directed();
        rdy_mode = 2;
        hs0 = hs_count;
        issue(0, 8'h20, 0, 0);
        t = 0;
        while (hs_count < hs0 + 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #3;
        check("mid_second_word_valid", 64'(bus.out_valid), 64'd1);
        check("mid_second_word", 64'(bus.out_word), 64'hE2800000);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd0);
        check("abort_tpl_addr", 64'(tpl_addr), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        check("after_abort_busy", 64'(busy), 64'd0);
        check("after_abort_hs", 64'(hs_count), 64'(hs0 + 1));
        issue(0, 8'h03, 0, 1);
        wait_idle("after_abort");
        fixed_ops = '{8'h7F};
        issue(0, 8'h10, 0, 1);
        wait_idle("after_abort_bipush");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
